pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage OTTER pipeline. It merges the load-use hazard flag, the EX-stage taken-branch/jump redirect and instruction/data memory wait signals. From these it drives per-stage write-enables and bubble controls with fixed priority. It also keeps a one-cycle load-use stall state, a memory-wait watchdog and saturating stall/flush performance counters.

## Interface
Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt
- TIMEOUT, 1024, consecutive memory-wait cycles that set timeout_err (>=2)

Ports:
- CLK  in  1  pipeline clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- ld_use  in  1  load-use hazard: ID source register matches EX load destination
- br_taken  in  1  EX-stage branch/jump resolved taken; PC mux already selects target
- imem_busy  in  1  fetch for current PC not complete
- dmem_busy  in  1  MEM-stage load/store not complete
- cnt_clr  in  1  synchronous clear of stall_cnt/flush_cnt
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID load enable
- id_ex_write  out  1  ID/EX load enable
- ex_mem_write  out  1  EX/MEM load enable
- if_id_flush  out  1  load NOP into IF/ID (when if_id_write=1)
- id_ex_flush  out  1  load NOP into ID/EX (when id_ex_write=1)
- mem_wb_flush  out  1  load NOP into MEM/WB
- timeout_err  out  1  sticky watchdog flag
- stall_cnt  out  CNT_W  cycles with pc_write=0, saturating
- flush_cnt  out  CNT_W  accepted redirects, saturating

## Operation
State register: RUN, LDSTALL. Control outputs are combinational from state and inputs. The first matching rule applies:
1. dmem_busy: pc_write=if_id_write=id_ex_write=ex_mem_write=0, mem_wb_flush=1, other flushes 0. State holds.
2. br_taken: all writes 1, if_id_flush=1, id_ex_flush=1. Overrides ld_use and imem_busy; the wrong-path fetch is discarded. flush_cnt increments. Next state RUN.
3. ld_use and state==RUN: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1, ex_mem_write=1. Next state LDSTALL.
4. imem_busy: pc_write=0, if_id_write=1, if_id_flush=1, rest advance normally. Next state RUN.
5. Otherwise: all writes 1, all flushes 0. Next state RUN.

Further rules:
- ld_use in LDSTALL is ignored, because the load is now in MEM and forwarding covers it. LDSTALL always returns to RUN on the next non-dmem_busy cycle.
- Watchdog: wait_cnt counts consecutive cycles with dmem_busy or imem_busy, and clears on any cycle with neither. When wait_cnt reaches TIMEOUT-1 while a wait is still asserted, timeout_err is set. Only reset clears timeout_err. wait_cnt saturates.
- Counters: stall_cnt increments on every cycle with pc_write=0. Both counters saturate at all-ones. cnt_clr wins over a same-cycle increment.

## Timing
- Reset (RST_N low, async):
  - state=RUN, wait_cnt=0, timeout_err=0, counters=0.
  - While RST_N is low, outputs are forced to: all writes 0, if_id_flush=id_ex_flush=mem_wb_flush=1.
- First edge after release: normal rule evaluation.
- Control outputs have zero latency, with the same-cycle decode used by pipeline registers at the next edge. Counters and timeout_err update one edge after the triggering cycle.
- Load-use stall is exactly one bubble: ld_use held for two cycles gives pc_write 0 then 1.
- dmem_busy during LDSTALL freezes the pipe and preserves LDSTALL, so the bubble is not reissued afterward.
- br_taken and dmem_busy in the same cycle: the freeze wins. br_taken remains asserted because EX is frozen, and the redirect applies on the first non-busy cycle.

## Test plan
- Reset then idle: outputs during RST_N=0 are as specified. After release, all writes=1, flushes=0, counters=0.
- ld_use=1 for 2 cycles: cycle 1 gives pc_write=0, id_ex_flush=1. Cycle 2 gives pc_write=1. stall_cnt=1.
- br_taken=1 with ld_use=1 and imem_busy=1 in the same cycle: if_id_flush=id_ex_flush=1, pc_write=1, flush_cnt=1, stall_cnt=0.
- ld_use enters LDSTALL, then dmem_busy for 3 cycles: freeze for 3 cycles with mem_wb_flush=1, then normal flow with no second bubble. stall_cnt=4.
- TIMEOUT=8, dmem_busy for 8 cycles: timeout_err=1 after the 8th cycle. It stays 1 after dmem_busy drops and clears only on RST_N.
- CNT_W=4, 20 stall cycles: stall_cnt saturates at 15. cnt_clr together with a stall gives stall_cnt=0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Hazard/wait inputs and stage-control outputs of the OTTER pipeline sequencer.
// The slave side is the sequencer itself; the master side is the pipeline datapath.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ld_use;
    logic             br_taken;
    logic             imem_busy;
    logic             dmem_busy;
    logic             cnt_clr;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ld_use, br_taken, imem_busy, dmem_busy, cnt_clr,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_flush,
               timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  ld_use, br_taken, imem_busy, dmem_busy, cnt_clr,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_flush,
               timeout_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: fixed-priority stage control, one-bubble load-use stall,
// memory-wait watchdog and saturating stall/flush performance counters.
module pipeline_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic            CLK,
    input  logic            RST_N,
    pipeline_ctrl_if.slave  bus
);

    typedef enum logic {RUN, LDSTALL} state_e;

    localparam int                WAIT_W   = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              timeout_err_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic pc_write_c, if_id_write_c, id_ex_write_c, ex_mem_write_c;
    logic if_id_flush_c, id_ex_flush_c, mem_wb_flush_c;
    logic redirect_c;
    logic waiting;

    assign waiting = bus.dmem_busy | bus.imem_busy;

    // NOTE: every output gets a default before the priority chain so no path infers a latch.
    always_comb begin
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        id_ex_write_c  = 1'b1;
        ex_mem_write_c = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        mem_wb_flush_c = 1'b0;
        redirect_c     = 1'b0;
        state_d        = RUN;

        if (bus.dmem_busy) begin
            // Freeze everything upstream of MEM; a pending redirect waits in EX.
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_write_c  = 1'b0;
            ex_mem_write_c = 1'b0;
            mem_wb_flush_c = 1'b1;
            state_d        = state_q;
        end else if (bus.br_taken) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            redirect_c    = 1'b1;
        end else if (bus.ld_use && state_q == RUN) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_flush_c = 1'b1;
            state_d       = LDSTALL;
        end else if (bus.imem_busy) begin
            pc_write_c    = 1'b0;
            if_id_flush_c = 1'b1;
        end
    end

    // Reset holds every stage and fills the pipe with bubbles.
    always_comb begin
        bus.pc_write     = RST_N & pc_write_c;
        bus.if_id_write  = RST_N & if_id_write_c;
        bus.id_ex_write  = RST_N & id_ex_write_c;
        bus.ex_mem_write = RST_N & ex_mem_write_c;
        bus.if_id_flush  = ~RST_N | if_id_flush_c;
        bus.id_ex_flush  = ~RST_N | id_ex_flush_c;
        bus.mem_wb_flush = ~RST_N | mem_wb_flush_c;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q <= state_d;

            if (waiting) begin
                if (wait_cnt_q == WAIT_MAX) timeout_err_q <= 1'b1;
                else                        wait_cnt_q    <= wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_q <= '0;
            end

            if (bus.cnt_clr) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else begin
                if (!pc_write_c && stall_cnt_q != {CNT_W{1'b1}})
                    stall_cnt_q <= stall_cnt_q + 1'b1;
                if (redirect_c && flush_cnt_q != {CNT_W{1'b1}})
                    flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.timeout_err = timeout_err_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a scoreboard of expected control words
// plus counter/watchdog expectations from a small reference model.
module tb_pipeline_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int SAT     = 15;

    // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_flush}
    typedef struct packed {
        logic [6:0] ctrl;
    } exp_t;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;
    exp_t sb[$];

    logic m_ldstall;
    int   m_stall;
    int   m_flush;
    int   m_wait;
    logic m_err;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [6:0] ctrl_now();
        return {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
                bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
    endfunction

    task automatic model_reset();
        m_ldstall = 1'b0;
        m_stall   = 0;
        m_flush   = 0;
        m_wait    = 0;
        m_err     = 1'b0;
        sb.delete();
    endtask

    // One clock cycle: drive inputs, check combinational controls, clock, check registered state.
    task automatic step(input logic ld, input logic br, input logic ib, input logic db,
                        input logic clr);
        exp_t       e;
        exp_t       got_e;
        logic [6:0] got;
        logic       redirect;
        bus.ld_use    = ld;
        bus.br_taken  = br;
        bus.imem_busy = ib;
        bus.dmem_busy = db;
        bus.cnt_clr   = clr;
        #1;
        redirect = 1'b0;
        if (db)                    e.ctrl = 7'b0000_001;
        else if (br) begin         e.ctrl = 7'b1111_110; redirect = 1'b1; end
        else if (ld && !m_ldstall) e.ctrl = 7'b0011_010;
        else if (ib)               e.ctrl = 7'b0111_100;
        else                       e.ctrl = 7'b1111_000;
        sb.push_back(e);

        got   = ctrl_now();
        got_e = sb.pop_front();
        checks++;
        if (got !== got_e.ctrl) begin
            errors++;
            $display("FAIL ctrl t=%0t in(ld=%b br=%b ib=%b db=%b) got=%b exp=%b",
                     $time, ld, br, ib, db, got, got_e.ctrl);
        end

        if (!db) m_ldstall = !br && ld && !m_ldstall;
        if (db || ib) begin
            if (m_wait == TIMEOUT - 1) m_err = 1'b1;
            else                       m_wait++;
        end else begin
            m_wait = 0;
        end
        if (clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!got_e.ctrl[6] && m_stall < SAT) m_stall++;
            if (redirect && m_flush < SAT)       m_flush++;
        end

        @(posedge CLK);
        #1;
        checks++;
        if (bus.stall_cnt !== CNT_W'(m_stall)) begin
            errors++;
            $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, bus.stall_cnt, m_stall);
        end
        checks++;
        if (bus.flush_cnt !== CNT_W'(m_flush)) begin
            errors++;
            $display("FAIL flush_cnt t=%0t got=%0d exp=%0d", $time, bus.flush_cnt, m_flush);
        end
        checks++;
        if (bus.timeout_err !== m_err) begin
            errors++;
            $display("FAIL timeout_err t=%0t got=%b exp=%b", $time, bus.timeout_err, m_err);
        end
    endtask

    task automatic do_reset();
        bus.ld_use    = 1'b1;
        bus.br_taken  = 1'b1;
        bus.imem_busy = 1'b1;
        bus.dmem_busy = 1'b0;
        bus.cnt_clr   = 1'b0;
        RST_N = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ctrl_now() !== 7'b0000_111) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=%b", ctrl_now(), 7'b0000_111);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got stall=%0d flush=%0d err=%b exp 0/0/0",
                     bus.stall_cnt, bus.flush_cnt, bus.timeout_err);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        step(0, 0, 0, 0, 0);
        checks++;
        if (ctrl_now() !== 7'b1111_000 || bus.stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL idle_after_reset got ctrl=%b stall=%0d exp ctrl=1111000 stall=0",
                     ctrl_now(), bus.stall_cnt);
        end
    endtask

    task automatic test_load_use();
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++;
        if (bus.stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL load_use_stall_cnt got=%0d exp=1", bus.stall_cnt);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_branch_priority();
        step(0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0);
        checks++;
        if (bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL branch_priority got flush=%0d stall=%0d exp flush=1 stall=0",
                     bus.flush_cnt, bus.stall_cnt);
        end
    endtask

    task automatic test_ldstall_freeze();
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        #1;
        step(1, 0, 0, 0, 0);
        checks++;
        if (bus.stall_cnt !== 4'd4) begin
            errors++;
            $display("FAIL ldstall_freeze_stall_cnt got=%0d exp=4", bus.stall_cnt);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_branch_during_freeze();
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        checks++;
        if (bus.flush_cnt !== 4'd1) begin
            errors++;
            $display("FAIL branch_after_freeze_flush_cnt got=%0d exp=1", bus.flush_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 1, 0);
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got=%b exp=0", bus.timeout_err);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set got=%b exp=1", bus.timeout_err);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        checks++;
        if (bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got=%b exp=1", bus.timeout_err);
        end
        do_reset();
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cleared got=%b exp=0", bus.timeout_err);
        end
        // A wait that ends one cycle short must not trip the watchdog.
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
        checks++;
        if (bus.stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL stall_saturate got=%0d exp=15", bus.stall_cnt);
        end
        step(0, 0, 1, 0, 1);
        checks++;
        if (bus.stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clr_wins_stall got=%0d exp=0", bus.stall_cnt);
        end
        for (int i = 0; i < 18; i++) step(0, 1, 0, 0, 0);
        checks++;
        if (bus.flush_cnt !== 4'd15) begin
            errors++;
            $display("FAIL flush_saturate got=%0d exp=15", bus.flush_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 40) == 0));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST_N  = 1'b0;
        bus.ld_use    = 1'b0;
        bus.br_taken  = 1'b0;
        bus.imem_busy = 1'b0;
        bus.dmem_busy = 1'b0;
        bus.cnt_clr   = 1'b0;
        model_reset();
        #2;

        test_reset();
        test_load_use();
        test_branch_priority();
        test_ldstall_freeze();
        test_branch_during_freeze();
        test_timeout();
        test_saturation();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
